// File: rtl/crossbar_mac_array_pkg.sv
// Shared opcode and sequencer state encodings for the ReRAM crossbar stand-in.
// Imported by the crossbar top level; the per-column popcount needs none of it.
package crossbar_mac_array_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_FORM  = 3'd1,
    OP_SET   = 3'd2,
    OP_RESET = 3'd3,
    OP_READ  = 3'd4,
    OP_MAC   = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_MAC   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_FORM) || (op == OP_SET) || (op == OP_RESET);
  endfunction

endpackage

// File: rtl/crossbar_mac_array_if.sv
// Command/response bus between the user-area controller (master) and the crossbar model (slave).
interface crossbar_mac_array_if #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int IN_BITS = 4
);
  localparam int ROW_AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ACC_W  = $clog2(ROWS + 1) + IN_BITS;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [ROW_AW-1:0]         cmd_row;
  logic [COLS-1:0]           cmd_col_mask;
  logic [ROWS*IN_BITS-1:0]   cmd_act;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [COLS*ACC_W-1:0]     rsp_data;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col_mask, cmd_act, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col_mask, cmd_act, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/crossbar_mac_array_col_popcount.sv
// Counts the conducting cells on one bitline for a single activation bit-plane.
module crossbar_mac_array_col_popcount #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/crossbar_mac_array.sv
// Behavioural ROWS x COLS 1T1R crossbar with command sequencer: forming, SET/RESET, row read, bit-serial MAC.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | cmd_ready high, waiting for a command
//  ST_WRITE | FORM/SET/RESET pulse held; array updated when counter hits 0
//  ST_READ  | one-cycle row sense
//  ST_MAC   | one activation bit-plane per cycle, MSB first
//  ST_RESP  | response held until rsp_ready
module crossbar_mac_array
  import crossbar_mac_array_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int IN_BITS      = 4,
  parameter int WRITE_CYCLES = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  crossbar_mac_array_if.slave  bus
);

  localparam int ROW_AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ROW_SPAN = 2 ** ROW_AW;
  localparam int PC_W     = $clog2(ROWS + 1);
  localparam int ACC_W    = PC_W + IN_BITS;
  localparam int BIT_W    = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam int WC_W     = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam int CNT_W    = (WC_W > BIT_W) ? WC_W : BIT_W;

  localparam logic [CNT_W-1:0]    WR_LOAD  = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    MAC_LOAD = CNT_W'(IN_BITS - 1);
  // One bit per encodable row address; addresses past ROWS map to 0.
  localparam logic [ROW_SPAN-1:0] ROW_OK   = {ROW_SPAN{1'b1}} >> (ROW_SPAN - ROWS);

  state_e                               state_q, state_d;
  op_e                                  op_q, op_d;
  logic [ROW_AW-1:0]                    row_q, row_d;
  logic [COLS-1:0]                      mask_q, mask_d;
  logic [ROWS-1:0][IN_BITS-1:0]         act_q, act_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [COLS-1:0][ACC_W-1:0]           acc_q, acc_d;
  logic [ROWS-1:0][COLS-1:0]            cell_q, cell_d;
  logic [ROWS-1:0][COLS-1:0]            formed_q, formed_d;
  logic                                 cmd_ready_q, cmd_ready_d;
  logic                                 rsp_valid_q, rsp_valid_d;
  logic [COLS-1:0][ACC_W-1:0]           rsp_data_q, rsp_data_d;
  logic                                 rsp_err_q, rsp_err_d;
  logic                                 busy_q, busy_d;

  logic                                 row_ok;
  logic                                 wr_err;
  logic [BIT_W-1:0]                     bit_idx;
  logic [COLS-1:0][ROWS-1:0]            col_bits;
  logic [COLS-1:0][PC_W-1:0]            col_cnt;

  assign row_ok  = ROW_OK[bus.cmd_row];
  assign bit_idx = cnt_q[BIT_W-1:0];

  always_comb begin
    col_bits = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        col_bits[c][r] = cell_q[r][c] & act_q[r][bit_idx];
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    crossbar_mac_array_col_popcount #(
      .N (ROWS),
      .W (PC_W)
    ) u_popcount (
      .bits  (col_bits[c]),
      .count (col_cnt[c])
    );
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    row_d       = row_q;
    mask_d      = mask_q;
    act_d       = act_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    cell_d      = cell_q;
    formed_d    = formed_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    wr_err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          row_d  = bus.cmd_row;
          mask_d = bus.cmd_col_mask;
          act_d  = bus.cmd_act;
          acc_d  = '0;
          if (op_is_write(bus.cmd_op) && row_ok) begin
            op_d    = op_e'(bus.cmd_op);
            cnt_d   = WR_LOAD;
            state_d = ST_WRITE;
          end else if ((bus.cmd_op == OP_READ) && row_ok) begin
            state_d = ST_READ;
          end else if (bus.cmd_op == OP_MAC) begin
            cnt_d   = MAC_LOAD;
            state_d = ST_MAC;
          end else if (bus.cmd_op != OP_NOP) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end

      ST_WRITE: begin
        if (cnt_q == '0) begin
          for (int c = 0; c < COLS; c++) begin
            if (mask_q[c]) begin
              case (op_q)
                OP_FORM: begin
                  formed_d[row_q][c] = 1'b1;
                  cell_d[row_q][c]   = 1'b1;
                end
                OP_SET, OP_RESET: begin
                  // Unformed filaments cannot switch; flag and leave the cell alone.
                  if (formed_q[row_q][c]) cell_d[row_q][c] = (op_q == OP_SET);
                  else                    wr_err = 1'b1;
                end
                default: ;
              endcase
            end
          end
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = wr_err;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_READ: begin
        rsp_data_d = '0;
        for (int c = 0; c < COLS; c++) begin
          rsp_data_d[c] = ACC_W'(cell_q[row_q][c] & formed_q[row_q][c]);
        end
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        state_d     = ST_RESP;
      end

      ST_MAC: begin
        for (int c = 0; c < COLS; c++) begin
          acc_d[c] = {acc_q[c][ACC_W-2:0], 1'b0} + ACC_W'(col_cnt[c]);
        end
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = acc_d;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      row_q       <= '0;
      mask_q      <= '0;
      act_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      cell_q      <= '0;
      formed_q    <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      row_q       <= row_d;
      mask_q      <= mask_d;
      act_q       <= act_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      cell_q      <= cell_d;
      formed_q    <= formed_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_crossbar_mac_array.sv
// Scoreboard bench for crossbar_mac_array: a cell/formed model predicts every response.
module tb_crossbar_mac_array;

  localparam int ROWS         = 8;
  localparam int COLS         = 8;
  localparam int IN_BITS      = 4;
  localparam int WRITE_CYCLES = 3;
  localparam int ACC_W        = 8;
  localparam int DW           = COLS * ACC_W;
  localparam int AW           = ROWS * IN_BITS;

  localparam logic [2:0] C_NOP = 3'd0, C_FORM = 3'd1, C_SET = 3'd2, C_RESET = 3'd3;
  localparam logic [2:0] C_READ = 3'd4, C_MAC = 3'd5;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  bit   cell_m [ROWS][COLS];
  bit   formed_m [ROWS][COLS];

  always #5 clk = ~clk;

  crossbar_mac_array_if #(.ROWS(ROWS), .COLS(COLS), .IN_BITS(IN_BITS)) bus ();

  crossbar_mac_array #(
    .ROWS(ROWS), .COLS(COLS), .IN_BITS(IN_BITS), .WRITE_CYCLES(WRITE_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        cell_m[r][c]   = 1'b0;
        formed_m[r][c] = 1'b0;
      end
  endtask

  task automatic model_cmd(input logic [2:0] op, input int row, input logic [COLS-1:0] mask,
                           input logic [AW-1:0] act, output exp_t e);
    int sum;
    e.data = '0;
    e.err  = 1'b0;
    case (op)
      C_FORM, C_SET, C_RESET: begin
        e.lat = WRITE_CYCLES + 1;
        for (int c = 0; c < COLS; c++) begin
          if (mask[c]) begin
            if (op == C_FORM) begin
              formed_m[row][c] = 1'b1;
              cell_m[row][c]   = 1'b1;
            end else if (!formed_m[row][c]) e.err = 1'b1;
            else cell_m[row][c] = (op == C_SET);
          end
        end
      end
      C_READ: begin
        e.lat = 2;
        for (int c = 0; c < COLS; c++)
          e.data[c*ACC_W +: ACC_W] = ACC_W'(cell_m[row][c] & formed_m[row][c]);
      end
      C_MAC: begin
        e.lat = IN_BITS + 1;
        for (int c = 0; c < COLS; c++) begin
          sum = 0;
          for (int r = 0; r < ROWS; r++)
            if (cell_m[r][c]) sum += int'(act[r*IN_BITS +: IN_BITS]);
          e.data[c*ACC_W +: ACC_W] = ACC_W'(sum);
        end
      end
      default: begin
        e.lat = 1;
        e.err = 1'b1;
      end
    endcase
  endtask

  task automatic drive_accept(input string name, input logic [2:0] op, input int row,
                              input logic [COLS-1:0] mask, input logic [AW-1:0] act);
    int n = 0;
    @(negedge clk);
    bus.cmd_op       = op;
    bus.cmd_row      = 3'(row);
    bus.cmd_col_mask = mask;
    bus.cmd_act      = act;
    bus.cmd_valid    = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s accept: cmd_ready=%b required 1", name, bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input string name, input logic [2:0] op, input int row,
                        input logic [COLS-1:0] mask, input logic [AW-1:0] act);
    exp_t e, x;
    int   lat;
    model_cmd(op, row, mask, act, e);
    sb_q.push_back(e);
    drive_accept(name, op, row, mask, act);
    wait_rsp(lat);
    x = sb_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp timeout: rsp_valid=%b required 1", name, bus.rsp_valid);
    end else begin
      checks += 3;
      if (bus.rsp_data !== x.data) begin
        errors++;
        $display("FAIL %s rsp_data got %h required %h", name, bus.rsp_data, x.data);
      end
      if (bus.rsp_err !== x.err) begin
        errors++;
        $display("FAIL %s rsp_err got %b required %b", name, bus.rsp_err, x.err);
      end
      if (lat != x.lat) begin
        errors++;
        $display("FAIL %s latency got %0d required %0d", name, lat, x.lat);
      end
    end
    consume();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
        bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs got rdy=%b vld=%b data=%h err=%b busy=%b required 1 0 0 0 0",
               name, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy);
    end
  endtask

  task automatic test_reset();
    check_idle_outputs("reset");
    do_cmd("read_after_reset", C_READ, 0, 8'h00, '0);
  endtask

  task automatic test_set_unformed();
    do_cmd("set_unformed", C_SET, 2, 8'hFF, '0);
    do_cmd("read_unformed", C_READ, 2, 8'h00, '0);
  endtask

  task automatic test_form_reset();
    for (int r = 0; r < ROWS; r++) do_cmd("form_row", C_FORM, r, 8'hFF, '0);
    do_cmd("reset_row3", C_RESET, 3, 8'h0F, '0);
    do_cmd("read_row3", C_READ, 3, 8'h00, '0);
    do_cmd("read_row5", C_READ, 5, 8'h00, '0);
  endtask

  task automatic test_mac();
    do_cmd("set_row3", C_SET, 3, 8'h0F, '0);
    do_cmd("mac_all15", C_MAC, 0, 8'h00, {AW{1'b1}});
    do_cmd("mac_row0_5", C_MAC, 0, 8'h00, 32'h0000_0005);
    do_cmd("empty_mask", C_RESET, 1, 8'h00, '0);
    for (int i = 0; i < 6; i++) begin
      do_cmd("rand_write", ($urandom_range(0, 1) == 0) ? C_SET : C_RESET,
             int'($urandom_range(0, ROWS - 1)), 8'($urandom), '0);
      do_cmd("rand_mac", C_MAC, 0, 8'h00, 32'($urandom));
    end
  endtask

  task automatic test_illegal_nop();
    do_cmd("illegal_6", 3'd6, 0, 8'hFF, '0);
    do_cmd("illegal_7", 3'd7, 4, 8'hFF, '0);
    drive_accept("nop", C_NOP, 0, 8'hFF, '0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL nop_idle busy=%b vld=%b rdy=%b required 0 0 1",
                 bus.busy, bus.rsp_valid, bus.cmd_ready);
      end
      @(posedge clk);
      #1;
    end
    do_cmd("read_after_nop", C_READ, 3, 8'h00, '0);
  endtask

  task automatic test_hold();
    exp_t e, x;
    int   lat;
    logic [AW-1:0] act = 32'h1234_5678;
    model_cmd(C_MAC, 0, 8'h00, act, e);
    sb_q.push_back(e);
    drive_accept("hold_mac", C_MAC, 0, 8'h00, act);
    wait_rsp(lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc %0d vld=%b data=%h rdy=%b required 1 %h 0",
                 i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, e.data);
      end
      @(posedge clk);
      #1;
    end
    x = sb_q.pop_front();
    checks++;
    if (bus.rsp_err !== x.err || bus.rsp_data !== x.data) begin
      errors++;
      $display("FAIL hold_final err=%b data=%h required %b %h", bus.rsp_err, bus.rsp_data, x.err, x.data);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    do_cmd("b2b_first", C_READ, 0, 8'h00, '0);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready rdy=%b busy=%b required 1 0", bus.cmd_ready, bus.busy);
    end
    do_cmd("b2b_second", C_MAC, 0, 8'h00, 32'hFFFF_0000);
    do_cmd("b2b_third", 3'd6, 0, 8'h00, '0);
  endtask

  task automatic test_reset_mid();
    drive_accept("mac_abort", C_MAC, 0, 8'h00, {AW{1'b1}});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_mac");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd("read_after_mac_abort", C_READ, 0, 8'h00, '0);
    drive_accept("form_abort", C_FORM, 5, 8'hFF, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_write");
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd("read_after_write_abort", C_READ, 5, 8'h00, '0);
    do_cmd("set_after_write_abort", C_SET, 5, 8'h01, '0);
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = 3'd0;
    bus.cmd_row      = '0;
    bus.cmd_col_mask = '0;
    bus.cmd_act      = '0;
    bus.rsp_ready    = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_set_unformed();
    test_form_reset();
    test_mac();
    test_illegal_nop();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
